// File: rtl/expr_check_arbiter.sv
// Round-robin arbiter sharing one "digit (op digit)*" expression checker
// between two character-stream requesters; one verdict per string plus pass/fail counters.
module expr_check_arbiter #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req_valid,
  input  logic [15:0]      req_char,
  input  logic [1:0]       req_last,
  output logic [1:0]       req_ready,
  output logic             res_valid,
  output logic             res_ch,
  output logic             res_ok,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_t;
  typedef enum logic [1:0] {CK_START, CK_DIGIT, CK_OP, CK_FAIL} chk_t;

  arb_t             state_q, state_d;
  chk_t             chk_q, chk_d, chk_nxt;
  logic [LEN_W-1:0] len_q, len_d, len_nxt;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             res_valid_q, res_valid_d;
  logic             res_ch_q, res_ch_d;
  logic             res_ok_q, res_ok_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       sel_char;
  logic             sel_last;
  logic             hs;

  // Saturating at MAX_LEN+1 keeps an over-long string failed however long it runs.
  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] l);
    if (l == LEN_SAT) return l;
    return l + 1'b1;
  endfunction

  function automatic chk_t chk_step(input chk_t s, input logic [7:0] ch);
    logic is_digit;
    logic is_op;
    is_digit = (ch >= 8'd48) && (ch <= 8'd57);
    is_op    = (ch == 8'd42) || (ch == 8'd43);
    case (s)
      CK_START: return is_digit ? CK_DIGIT : CK_FAIL;
      CK_DIGIT: return is_op    ? CK_OP    : CK_FAIL;
      CK_OP:    return is_digit ? CK_DIGIT : CK_FAIL;
      default:  return CK_FAIL;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    chk_d        = chk_q;
    len_d        = len_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    res_valid_d  = 1'b0;
    res_ch_d     = res_ch_q;
    res_ok_d     = res_ok_q;
    ok_cnt_d     = ok_cnt_q;
    err_cnt_d    = err_cnt_q;
    req_ready    = 2'b00;

    sel_char = grant_q ? req_char[15:8] : req_char[7:0];
    sel_last = req_last[grant_q];
    hs       = (state_q == ARB_BUSY) && req_valid[grant_q];
    chk_nxt  = chk_step(chk_q, sel_char);
    len_nxt  = len_sat_inc(len_q);

    case (state_q)
      ARB_IDLE: begin
        if (|req_valid) begin
          // On a tie the requester that did not win last time gets the string.
          grant_d      = (&req_valid) ? ~last_grant_q : req_valid[1];
          last_grant_d = grant_d;
          state_d      = ARB_BUSY;
        end
      end
      default: begin
        req_ready[grant_q] = 1'b1;
        if (hs) begin
          if (sel_last) begin
            res_valid_d = 1'b1;
            res_ch_d    = grant_q;
            res_ok_d    = (chk_nxt == CK_DIGIT) && (len_nxt <= LEN_MAX);
            if (res_ok_d) ok_cnt_d  = ok_cnt_q + 1'b1;
            else          err_cnt_d = err_cnt_q + 1'b1;
            chk_d   = CK_START;
            len_d   = '0;
            state_d = ARB_IDLE;
          end else begin
            chk_d = chk_nxt;
            len_d = len_nxt;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= ARB_IDLE;
      chk_q        <= CK_START;
      len_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_ch_q     <= 1'b0;
      res_ok_q     <= 1'b0;
      ok_cnt_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      chk_q        <= chk_d;
      len_q        <= len_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_ch_q     <= res_ch_d;
      res_ok_q     <= res_ok_d;
      ok_cnt_q     <= ok_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_ok    = res_ok_q;
  assign ok_cnt    = ok_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_expr_check_arbiter.sv
// Directed self-checking bench for expr_check_arbiter: verdicts, round-robin ties,
// length limit, mid-string stalls and asynchronous clear.
module tb_expr_check_arbiter;

  localparam int BOUND = 200;

  logic        clk;
  logic        clr;
  logic        v [2];
  logic [7:0]  c [2];
  logic        l [2];
  logic [1:0]  req_valid;
  logic [15:0] req_char;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        res_valid;
  logic        res_ch;
  logic        res_ok;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;
  logic        busy;

  typedef struct packed {logic ch; logic ok;} verd_t;
  verd_t vq[$];
  int    rdy0_n  = 0;
  int    both_rdy = 0;
  int    checks  = 0;
  int    errors  = 0;

  assign req_valid = {v[1], v[0]};
  assign req_char  = {c[1], c[0]};
  assign req_last  = {l[1], l[0]};

  expr_check_arbiter #(.MAX_LEN(16), .CNT_W(16)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_char(req_char), .req_last(req_last),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_ch(res_ch), .res_ok(res_ok),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (res_valid) vq.push_back('{ch: res_ch, ok: res_ok});
    if (req_ready[0]) rdy0_n <= rdy0_n + 1;
    if (&req_ready) both_rdy <= both_rdy + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    v[0] = 1'b0; v[1] = 1'b0; l[0] = 1'b0; l[1] = 1'b0;
    c[0] = 8'd0; c[1] = 8'd0;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
  endtask

  // Offers string s on requester r; optional valid gap of gap_len cycles before char gap_at.
  task automatic drive(input int r, input string s, input int gap_at, input int gap_len);
    bit hs;
    int n;
    for (int i = 0; i < s.len(); i++) begin
      if (i == gap_at && gap_len > 0) begin
        v[r] = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          check("gap_ready", 32'(req_ready), 32'(2'b01) << r);
          check("gap_busy", 32'(busy), 32'd1);
          @(posedge clk); #1;
        end
      end
      v[r] = 1'b1;
      c[r] = s[i];
      l[r] = (i == s.len() - 1);
      hs = 1'b0;
      n = 0;
      while (!hs && n < BOUND) begin
        @(negedge clk);
        hs = req_ready[r];
        @(posedge clk); #1;
        n++;
      end
      if (!hs) begin
        check("hs_timeout", 32'd0, 32'd1);
        break;
      end
    end
    v[r] = 1'b0;
    l[r] = 1'b0;
  endtask

  task automatic verdict(input string tag, input int k, input logic ch, input logic ok);
    check({tag, "_ch"}, 32'(vq[k].ch), 32'(ch));
    check({tag, "_ok"}, 32'(vq[k].ok), 32'(ok));
  endtask

  initial begin
    int vb;
    int r0;
    string s;
    logic exp_ok [5];
    string t2 [5];

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ok_cnt", 32'(ok_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;

    // Requester 0: "1+2*3"
    vb = vq.size(); r0 = rdy0_n;
    drive(0, "1+2*3", -1, 0);
    repeat (2) @(posedge clk); #1;
    check("t1_nverd", 32'(vq.size() - vb), 32'd1);
    verdict("t1", vb, 1'b0, 1'b1);
    check("t1_rdy_cycles", 32'(rdy0_n - r0), 32'd5);
    check("t1_ok_cnt", 32'(ok_cnt), 32'd1);
    check("t1_err_cnt", 32'(err_cnt), 32'd0);

    // Requester 1: malformed strings then one good one
    do_reset();
    t2[0] = "1+";   exp_ok[0] = 1'b0;
    t2[1] = "+1";   exp_ok[1] = 1'b0;
    t2[2] = "12";   exp_ok[2] = 1'b0;
    t2[3] = "1++2"; exp_ok[3] = 1'b0;
    t2[4] = "7";    exp_ok[4] = 1'b1;
    vb = vq.size();
    for (int i = 0; i < 5; i++) drive(1, t2[i], -1, 0);
    repeat (2) @(posedge clk); #1;
    check("t2_nverd", 32'(vq.size() - vb), 32'd5);
    for (int i = 0; i < 5; i++) verdict({"t2_", t2[i]}, vb + i, 1'b1, exp_ok[i]);
    check("t2_err_cnt", 32'(err_cnt), 32'd4);
    check("t2_ok_cnt", 32'(ok_cnt), 32'd1);

    // Ties after reset: 0, then 1, then 0 again
    do_reset();
    vb = vq.size();
    fork
      drive(0, "5", -1, 0);
      drive(1, "6", -1, 0);
    join
    fork
      drive(0, "3", -1, 0);
      drive(1, "4", -1, 0);
    join
    repeat (2) @(posedge clk); #1;
    check("t3_nverd", 32'(vq.size() - vb), 32'd4);
    verdict("t3_a", vb,     1'b0, 1'b1);
    verdict("t3_b", vb + 1, 1'b1, 1'b1);
    verdict("t3_c", vb + 2, 1'b0, 1'b1);
    verdict("t3_d", vb + 3, 1'b1, 1'b1);

    // Length limit around MAX_LEN = 16 and counter saturation
    do_reset();
    vb = vq.size();
    drive(0, "1+1+1+1+1+1+1+1+1", -1, 0);
    drive(0, "1+1+1+1+1+1+1+1", -1, 0);
    s = "";
    for (int i = 0; i < 20; i++) s = {s, "1+"};
    drive(0, s, -1, 0);
    s = "";
    for (int i = 0; i < 16; i++) s = {s, "1+"};
    s = {s, "1"};
    drive(0, s, -1, 0);
    repeat (2) @(posedge clk); #1;
    check("t4_nverd", 32'(vq.size() - vb), 32'd4);
    verdict("t4_len17", vb,     1'b0, 1'b0);
    verdict("t4_len15", vb + 1, 1'b0, 1'b1);
    verdict("t4_len40", vb + 2, 1'b0, 1'b0);
    verdict("t4_len33", vb + 3, 1'b0, 1'b0);
    check("t4_ok_cnt", 32'(ok_cnt), 32'd1);
    check("t4_err_cnt", 32'(err_cnt), 32'd3);

    // Stall mid-string while requester 1 waits
    do_reset();
    vb = vq.size();
    fork
      drive(0, "1+2", 1, 3);
      drive(1, "8", -1, 0);
    join
    repeat (2) @(posedge clk); #1;
    check("t5_nverd", 32'(vq.size() - vb), 32'd2);
    verdict("t5_r0", vb,     1'b0, 1'b1);
    verdict("t5_r1", vb + 1, 1'b1, 1'b1);

    // Clear after the 2nd character discards the string
    do_reset();
    drive(0, "7", -1, 0);
    v[0] = 1'b1; c[0] = "1"; l[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    c[0] = "+";
    @(posedge clk); #1;
    check("t6_busy_pre", 32'(busy), 32'd1);
    check("t6_ok_pre", 32'(ok_cnt), 32'd1);
    vb = vq.size();
    c[0] = "2";
    clr = 1'b1;
    #1;
    check("t6_clr_ready", 32'(req_ready), 32'd0);
    check("t6_clr_valid", 32'(res_valid), 32'd0);
    check("t6_clr_res_ok", 32'(res_ok), 32'd0);
    check("t6_clr_busy", 32'(busy), 32'd0);
    check("t6_clr_ok_cnt", 32'(ok_cnt), 32'd0);
    v[0] = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t6_no_verd", 32'(vq.size() - vb), 32'd0);
    drive(0, "9", -1, 0);
    repeat (2) @(posedge clk); #1;
    check("t6_nverd", 32'(vq.size() - vb), 32'd1);
    verdict("t6_resend", vb, 1'b0, 1'b1);
    check("t6_ok_cnt", 32'(ok_cnt), 32'd1);

    check("both_ready", 32'(both_rdy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
